// File: rtl/rand_req_arbiter.sv
// rand_req_arbiter: shares one LFSR random source among the board setup
// generator (S), player A (A) and player B (B). A granted requester gets one
// RNG step per attempt; out-of-range samples are retried, and after the last
// allowed retry the sample is folded into [MIN_VAL, MAX_VAL].
module rand_req_arbiter #(
  parameter int         RNG_LAT   = 2,     // cycles for rand_* to follow a step, 1..15
  parameter logic [3:0] MIN_VAL   = 4'd1,  // lowest deliverable value
  parameter logic [3:0] MAX_VAL   = 4'd9,  // highest deliverable value, >= MIN_VAL
  parameter int         MAX_RETRY = 3      // rejected samples before folding, 0..7
) (
  input  logic       clka,
  input  logic       restart,
  input  logic       new_game,
  input  logic       req_setup,
  input  logic       req_A,
  input  logic       req_B,
  input  logic [3:0] rand_setup,
  input  logic [3:0] rand_A,
  input  logic [3:0] rand_B,
  output logic       gen_rand_flag,
  output logic [2:0] grant,
  output logic [3:0] rand_out,
  output logic       rand_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Round-robin pointer encoding: requester that is looked at first.
  localparam logic [1:0] RR_S = 2'd0;
  localparam logic [1:0] RR_A = 2'd1;
  localparam logic [1:0] RR_B = 2'd2;

  // Width of the accepted window; at most 16, so the fold result fits 4 bits.
  localparam int RANGE = int'(MAX_VAL) - int'(MIN_VAL) + 1;

  state_e     state_q;
  logic [2:0] grant_q;
  logic       flag_q;
  logic [3:0] rand_out_q;
  logic       valid_q;
  logic       busy_q;
  logic [2:0] retry_q;
  logic [3:0] wait_q;
  logic [1:0] rr_q;

  logic [2:0] grant_d;
  logic [1:0] rr_d;
  logic [3:0] raw_d;
  logic [3:0] fold_d;
  logic       in_range;
  logic       req_held;
  logic       drop;

  // Pick the first pending requester in round-robin order from the pointer.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    grant_d = 3'b000;
    case (rr_q)
      RR_A: begin
        if      (req_A)     grant_d = 3'b010;
        else if (req_B)     grant_d = 3'b100;
        else if (req_setup) grant_d = 3'b001;
      end
      RR_B: begin
        if      (req_B)     grant_d = 3'b100;
        else if (req_setup) grant_d = 3'b001;
        else if (req_A)     grant_d = 3'b010;
      end
      default: begin
        if      (req_setup) grant_d = 3'b001;
        else if (req_A)     grant_d = 3'b010;
        else if (req_B)     grant_d = 3'b100;
      end
    endcase
  end

  // Route the granted requester's nibble and request line; derive the next pointer.
  always_comb begin
    raw_d    = 4'd0;
    req_held = 1'b0;
    rr_d     = RR_S;
    case (grant_q)
      3'b001: begin raw_d = rand_setup; req_held = req_setup; rr_d = RR_A; end
      3'b010: begin raw_d = rand_A;     req_held = req_A;     rr_d = RR_B; end
      3'b100: begin raw_d = rand_B;     req_held = req_B;     rr_d = RR_S; end
      default: ;
    endcase
    in_range = (raw_d >= MIN_VAL) && (raw_d <= MAX_VAL);
    fold_d   = 4'(int'(MIN_VAL) + (int'(raw_d) % RANGE));
    // A requester may withdraw at any point before the result is decided.
    drop     = (state_q == ST_GEN || state_q == ST_WAIT || state_q == ST_CHECK) && !req_held;
  end

  // Arbitration FSM with all outputs held in registers.
  always_ff @(posedge clka) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (restart) begin
      state_q    <= ST_IDLE;
      grant_q    <= 3'b000;
      flag_q     <= 1'b0;
      rand_out_q <= 4'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      retry_q    <= 3'd0;
      wait_q     <= 4'd0;
      rr_q       <= RR_S;
    end else if (new_game) begin
      // Abort keeps the last delivered value visible.
      state_q <= ST_IDLE;
      grant_q <= 3'b000;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      retry_q <= 3'd0;
      wait_q  <= 4'd0;
      rr_q    <= RR_S;
    end else if (drop) begin
      // Withdrawn request: no result, pointer untouched.
      state_q <= ST_IDLE;
      grant_q <= 3'b000;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_setup || req_A || req_B) begin
            grant_q <= grant_d;
            retry_q <= 3'd0;
            flag_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_GEN;
          end
        end
        ST_GEN: begin
          wait_q  <= 4'(RNG_LAT - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == 4'd0) state_q <= ST_CHECK;
          else                wait_q  <= wait_q - 4'd1;
        end
        ST_CHECK: begin
          if (in_range) begin
            rand_out_q <= raw_d;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end else if (retry_q < 3'(MAX_RETRY)) begin
            retry_q <= retry_q + 3'd1;
            flag_q  <= 1'b1;
            state_q <= ST_GEN;
          end else begin
            rand_out_q <= fold_d;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          rr_q    <= rr_d;
          grant_q <= 3'b000;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          grant_q <= 3'b000;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gen_rand_flag = flag_q;
  assign grant         = grant_q;
  assign rand_out      = rand_out_q;
  assign rand_valid    = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Testbench for rand_req_arbiter with default parameters
// (RNG_LAT=2, MIN_VAL=1, MAX_VAL=9, MAX_RETRY=3).
// Edge numbering: edge 0 is the clock edge right before a request is driven.
module tb_rand_req_arbiter;

  logic       clka = 1'b0;
  logic       restart, new_game;
  logic       req_setup, req_A, req_B;
  logic [3:0] rand_setup, rand_A, rand_B;
  logic       gen_rand_flag;
  logic [2:0] grant;
  logic [3:0] rand_out;
  logic       rand_valid;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clka = ~clka;

  rand_req_arbiter dut (
    .clka          (clka),
    .restart       (restart),
    .new_game      (new_game),
    .req_setup     (req_setup),
    .req_A         (req_A),
    .req_B         (req_B),
    .rand_setup    (rand_setup),
    .rand_A        (rand_A),
    .rand_B        (rand_B),
    .gen_rand_flag (gen_rand_flag),
    .grant         (grant),
    .rand_out      (rand_out),
    .rand_valid    (rand_valid),
    .busy          (busy)
  );

  // One vector: requester, nibble for 1st/2nd/3rd+ RNG step, expected result.
  typedef struct {
    logic [2:0] req;
    logic [3:0] n0;
    logic [3:0] n1;
    logic [3:0] n2;
    logic [3:0] exp_out;
    logic [2:0] exp_grant;
    int         exp_edges;
    int         exp_flags;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic set_req(input logic [2:0] r);
    req_setup = r[0];
    req_A     = r[1];
    req_B     = r[2];
  endtask

  // Put value on the nibble of the requester(s) in r; others see 3.
  task automatic set_nib(input logic [2:0] r, input logic [3:0] val);
    rand_setup = r[0] ? val : 4'd3;
    rand_A     = r[1] ? val : 4'd3;
    rand_B     = r[2] ? val : 4'd3;
  endtask

  task automatic wait_valid(output int edges, output bit got);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 60) begin
      tick();
      edges++;
      if (rand_valid) got = 1'b1;
    end
  endtask

  initial begin
    int         edges, flags, nv, rises, overlap, stray;
    bit         got;
    logic [2:0] gseq[4];
    logic [2:0] gprev;

    vecs[0] = '{req:3'b001, n0:4'd5,  n1:4'd5,  n2:4'd5,  exp_out:4'd5, exp_grant:3'b001, exp_edges:5,  exp_flags:1};
    vecs[1] = '{req:3'b010, n0:4'd9,  n1:4'd9,  n2:4'd9,  exp_out:4'd9, exp_grant:3'b010, exp_edges:5,  exp_flags:1};
    vecs[2] = '{req:3'b100, n0:4'd1,  n1:4'd1,  n2:4'd1,  exp_out:4'd1, exp_grant:3'b100, exp_edges:5,  exp_flags:1};
    vecs[3] = '{req:3'b010, n0:4'd0,  n1:4'd12, n2:4'd7,  exp_out:4'd7, exp_grant:3'b010, exp_edges:13, exp_flags:3};
    vecs[4] = '{req:3'b100, n0:4'd14, n1:4'd14, n2:4'd14, exp_out:4'd6, exp_grant:3'b100, exp_edges:17, exp_flags:4};
    vecs[5] = '{req:3'b001, n0:4'd0,  n1:4'd0,  n2:4'd0,  exp_out:4'd1, exp_grant:3'b001, exp_edges:17, exp_flags:4};
    vecs[6] = '{req:3'b010, n0:4'd10, n1:4'd10, n2:4'd10, exp_out:4'd2, exp_grant:3'b010, exp_edges:17, exp_flags:4};
    vecs[7] = '{req:3'b100, n0:4'd15, n1:4'd15, n2:4'd15, exp_out:4'd7, exp_grant:3'b100, exp_edges:17, exp_flags:4};
    vecs[8] = '{req:3'b001, n0:4'd15, n1:4'd10, n2:4'd9,  exp_out:4'd9, exp_grant:3'b001, exp_edges:13, exp_flags:3};

    // Reset, then idle quietly.
    restart  = 1'b1;
    new_game = 1'b0;
    set_req(3'b000);
    set_nib(3'b000, 4'd0);
    tick();
    tick();
    restart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("reset_idle_outputs", 32'({gen_rand_flag, grant, rand_out, rand_valid, busy}), 0);
      tick();
    end

    // Table of single-requester transactions.
    for (int v = 0; v < 9; v++) begin
      set_nib(vecs[v].req, vecs[v].n0);
      set_req(vecs[v].req);
      edges = 0;
      flags = 0;
      got   = 1'b0;
      while (!got && edges < 40) begin
        tick();
        edges++;
        if (gen_rand_flag) begin
          flags++;
          set_nib(vecs[v].req, (flags == 1) ? vecs[v].n0 : (flags == 2) ? vecs[v].n1 : vecs[v].n2);
        end
        if (rand_valid) got = 1'b1;
      end
      check($sformatf("vec%0d_valid_seen", v), 32'(got), 1);
      check($sformatf("vec%0d_latency", v), edges, vecs[v].exp_edges);
      check($sformatf("vec%0d_rand_out", v), 32'(rand_out), 32'(vecs[v].exp_out));
      check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
      check($sformatf("vec%0d_flag_pulses", v), flags, vecs[v].exp_flags);
      set_req(3'b000);
      tick();
      check($sformatf("vec%0d_after_done", v), 32'({busy, grant, rand_valid}), 0);
    end

    // Flag timing: pulse in the first cycle of the transaction only.
    set_nib(3'b001, 4'd5);
    set_req(3'b001);
    tick();
    check("gen_first_cycle", 32'({gen_rand_flag, busy, grant}), 32'(5'b11001));
    tick();
    check("gen_second_cycle", 32'({gen_rand_flag, busy}), 32'(2'b01));
    wait_valid(edges, got);
    check("gen_seq_valid_edge", edges, 3);
    set_req(3'b000);
    tick();

    // All three requesters held: strict S, A, B, S rotation after reset.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    set_nib(3'b111, 4'd5);
    set_req(3'b111);
    nv      = 0;
    rises   = 0;
    overlap = 0;
    gprev   = 3'b000;
    for (int c = 0; c < 200 && nv < 4; c++) begin
      tick();
      if ($countones(grant) > 1) overlap++;
      if (gprev == 3'b000 && grant != 3'b000) rises++;
      gprev = grant;
      if (rand_valid) begin
        gseq[nv] = grant;
        nv++;
      end
    end
    set_req(3'b000);
    check("rr_valid_count", nv, 4);
    check("rr_grant0", 32'(gseq[0]), 32'(3'b001));
    check("rr_grant1", 32'(gseq[1]), 32'(3'b010));
    check("rr_grant2", 32'(gseq[2]), 32'(3'b100));
    check("rr_grant3", 32'(gseq[3]), 32'(3'b001));
    check("rr_grant_periods", rises, 4);
    check("rr_grant_overlap", overlap, 0);
    tick();

    // Serve A alone so the pointer moves to B.
    set_nib(3'b010, 4'd5);
    set_req(3'b010);
    wait_valid(edges, got);
    check("a_alone_valid", 32'(got), 1);
    set_req(3'b000);
    tick();

    // new_game during WAIT aborts and points the arbiter back at S.
    set_req(3'b010);
    tick();
    tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("newgame_abort", 32'({gen_rand_flag, grant, rand_valid, busy}), 0);
    check("newgame_holds_out", 32'(rand_out), 5);
    set_nib(3'b110, 4'd4);
    set_req(3'b110);
    tick();
    check("newgame_next_grant", 32'(grant), 32'(3'b010));
    wait_valid(edges, got);
    check("newgame_a_valid_grant", 32'({got, grant}), 32'(4'b1010));
    check("newgame_a_out", 32'(rand_out), 4);
    set_req(3'b100);
    wait_valid(edges, got);
    check("newgame_b_valid_grant", 32'({got, grant}), 32'(4'b1100));
    set_req(3'b000);
    tick();

    // Serve S alone so the pointer moves to A, then A withdraws in WAIT.
    set_req(3'b001);
    wait_valid(edges, got);
    check("s_alone_valid", 32'(got), 1);
    set_req(3'b000);
    tick();
    set_req(3'b010);
    tick();
    tick();
    set_req(3'b000);
    tick();
    check("drop_to_idle", 32'({grant, busy}), 0);
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rand_valid || gen_rand_flag || busy) stray++;
    end
    check("drop_no_activity", stray, 0);
    // Pointer still at A: with all three pending A wins.
    set_req(3'b111);
    tick();
    check("drop_pointer_kept", 32'(grant), 32'(3'b010));
    set_req(3'b000);
    tick();
    check("drop_in_gen_idle", 32'({grant, busy}), 0);

    // restart clears the delivered value.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_clears_out", 32'(rand_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
